// File: rtl/rsi_cmp_sched_pkg.sv
// Shared types, reset defaults and the fp32 greater-than helper used by the
// RSI compare scheduler.
package rsi_cmp_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CMP_HI = 2'd1,
    ST_CMP_LO = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic [31:0] LOW_RST_DEF  = 32'h41F0_0000;  // 30.0
  localparam logic [31:0] HIGH_RST_DEF = 32'h428C_0000;  // 70.0

  localparam logic CFG_SEL_LOW  = 1'b0;
  localparam logic CFG_SEL_HIGH = 1'b1;

  function automatic logic fp_is_nan(input logic [31:0] f);
    return (f[30:23] == 8'hFF) && (f[22:0] != 23'd0);
  endfunction

  // IEEE-754 single a > b: false for any NaN operand, +0 and -0 compare equal.
  function automatic logic fp_gt(input logic [31:0] a, input logic [31:0] b);
    logic r;
    if (fp_is_nan(a) || fp_is_nan(b)) begin
      r = 1'b0;
    end else if ((a[30:0] == 31'd0) && (b[30:0] == 31'd0)) begin
      r = 1'b0;
    end else if (a[31] != b[31]) begin
      r = b[31];
    end else if (a[31] == 1'b0) begin
      r = (a[30:0] > b[30:0]);
    end else begin
      r = (a[30:0] < b[30:0]);
    end
    return r;
  endfunction

endpackage

// File: rtl/rsi_cmp_sched_if.sv
// Request, threshold-config and decision handshake bundle of the RSI compare
// scheduler. master = indicator/order side, slave = scheduler.
interface rsi_cmp_sched_if #(
  parameter int NCH = 4,
  parameter int CHW = 2
);
  import rsi_cmp_sched_pkg::*;

  logic [NCH-1:0]     req_valid;
  logic [32*NCH-1:0]  req_value;
  logic [NCH-1:0]     req_ready;
  logic               cfg_we;
  logic [CHW-1:0]     cfg_ch;
  logic               cfg_sel;
  logic [31:0]        cfg_data;
  logic               res_valid;
  logic               res_ready;
  logic [CHW-1:0]     res_ch;
  logic               res_buy;
  logic               res_sell;
  logic               res_hold;

  modport master (
    output req_valid, req_value, cfg_we, cfg_ch, cfg_sel, cfg_data, res_ready,
    input  req_ready, res_valid, res_ch, res_buy, res_sell, res_hold
  );

  modport slave (
    input  req_valid, req_value, cfg_we, cfg_ch, cfg_sel, cfg_data, res_ready,
    output req_ready, res_valid, res_ch, res_buy, res_sell, res_hold
  );

endinterface

// File: rtl/rsi_cmp_sched_rr_arbiter.sv
// Round-robin arbiter: search starts one past the last winner and wraps;
// the first asserted request wins.
module rr_arbiter #(
  parameter int NCH = 4,
  parameter int CHW = 2
) (
  input  logic [NCH-1:0] req_i,
  input  logic [CHW-1:0] ptr_i,
  output logic [NCH-1:0] gnt_o,
  output logic [CHW-1:0] idx_o,
  output logic           any_o
);

  logic [NCH-1:0] gnt_s;
  logic [CHW-1:0] idx_s;
  logic           any_s;
  logic           hit_s;
  int             pos_s;

  // Walk the channels in rotated order and keep the first requester.
  always_comb begin
    gnt_s = '0;
    idx_s = '0;
    any_s = 1'b0;
    hit_s = 1'b0;
    pos_s = 0;
    for (int i = 1; i <= NCH; i++) begin
      pos_s        = (int'(ptr_i) + i) % NCH;
      hit_s        = !any_s && req_i[pos_s];
      gnt_s[pos_s] = gnt_s[pos_s] | hit_s;
      idx_s        = hit_s ? CHW'(pos_s) : idx_s;
      any_s        = any_s | hit_s;
    end
  end

  assign gnt_o = gnt_s;
  assign idx_o = idx_s;
  assign any_o = any_s;

endmodule

// File: rtl/rsi_cmp_sched.sv
// RSI compare scheduler: shares one fp32 greater-than between NCH channels,
// runs value>high then low>value for the granted channel and returns a
// one-hot BUY/SELL/HOLD decision tagged with the channel.
module rsi_cmp_sched
  import rsi_cmp_sched_pkg::*;
#(
  parameter int          NCH      = 4,
  parameter int          CHW      = 2,
  parameter logic [31:0] LOW_RST  = LOW_RST_DEF,
  parameter logic [31:0] HIGH_RST = HIGH_RST_DEF
) (
  input  logic           clk,
  input  logic           rst,
  rsi_cmp_sched_if.slave bus
);

  state_e          state_q;
  logic [CHW-1:0]  ptr_q;
  logic [31:0]     value_q;
  logic [31:0]     low_q;
  logic [31:0]     high_q;
  logic            gt_hi_q;
  logic            res_valid_q;
  logic [CHW-1:0]  res_ch_q;
  logic            res_buy_q;
  logic            res_sell_q;
  logic            res_hold_q;
  logic [31:0]     lo_thr_q [NCH];
  logic [31:0]     hi_thr_q [NCH];

  logic [NCH-1:0]  gnt_s;
  logic [CHW-1:0]  gidx_s;
  logic            any_s;
  logic [31:0]     f1_s;
  logic [31:0]     f2_s;
  logic            gt_s;
  logic            cfg_ok_s;

  rr_arbiter #(.NCH(NCH), .CHW(CHW)) u_arb (
    .req_i (bus.req_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt_s),
    .idx_o (gidx_s),
    .any_o (any_s)
  );

  // Grants are only offered while idle; the grant itself is combinational.
  assign bus.req_ready = (state_q == ST_IDLE) ? gnt_s : '0;
  assign bus.res_valid = res_valid_q;
  assign bus.res_ch    = res_ch_q;
  assign bus.res_buy   = res_buy_q;
  assign bus.res_sell  = res_sell_q;
  assign bus.res_hold  = res_hold_q;

  assign cfg_ok_s = bus.cfg_we && (int'(bus.cfg_ch) < NCH);
  assign gt_s     = fp_gt(f1_s, f2_s);

  // Steer the shared comparator: value vs high first, then low vs value.
  always_comb begin
    f1_s = 32'd0;
    f2_s = 32'd0;
    case (state_q)
      ST_CMP_HI: begin
        f1_s = value_q;
        f2_s = high_q;
      end
      ST_CMP_LO: begin
        f1_s = low_q;
        f2_s = value_q;
      end
      default: begin
        f1_s = 32'd0;
        f2_s = 32'd0;
      end
    endcase
  end

  // Per-channel threshold store; out-of-range channel writes are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        lo_thr_q[i] <= LOW_RST;
        hi_thr_q[i] <= HIGH_RST;
      end
    end else if (cfg_ok_s) begin
      if (bus.cfg_sel == CFG_SEL_HIGH) begin
        hi_thr_q[bus.cfg_ch] <= bus.cfg_data;
      end else begin
        lo_thr_q[bus.cfg_ch] <= bus.cfg_data;
      end
    end
  end

  // Scheduler FSM; thresholds are snapshotted in the grant cycle so a
  // concurrent cfg write only affects the following request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= CHW'(NCH - 1);
      value_q     <= 32'd0;
      low_q       <= 32'd0;
      high_q      <= 32'd0;
      gt_hi_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_ch_q    <= '0;
      res_buy_q   <= 1'b0;
      res_sell_q  <= 1'b0;
      res_hold_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_s) begin
            value_q <= bus.req_value[32*int'(gidx_s) +: 32];
            low_q   <= lo_thr_q[gidx_s];
            high_q  <= hi_thr_q[gidx_s];
            ptr_q   <= gidx_s;
            state_q <= ST_CMP_HI;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_CMP_HI: begin
          gt_hi_q <= gt_s;
          state_q <= ST_CMP_LO;
        end
        ST_CMP_LO: begin
          res_valid_q <= 1'b1;
          res_ch_q    <= ptr_q;
          res_sell_q  <= gt_hi_q;
          res_buy_q   <= !gt_hi_q && gt_s;
          res_hold_q  <= !gt_hi_q && !gt_s;
          state_q     <= ST_DONE;
        end
        ST_DONE: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            res_buy_q   <= 1'b0;
            res_sell_q  <= 1'b0;
            res_hold_q  <= 1'b0;
            state_q     <= ST_IDLE;
          end else begin
            state_q     <= ST_DONE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rsi_cmp_sched.sv
// Bench for rsi_cmp_sched: a negedge monitor predicts every decision from a
// real-valued threshold model at grant time and checks it when it emerges.
module tb_rsi_cmp_sched;

  localparam int NCH = 4;
  localparam int CHW = 2;

  localparam logic [31:0] V20 = 32'h41A0_0000;
  localparam logic [31:0] V25 = 32'h41C8_0000;
  localparam logic [31:0] V30 = 32'h41F0_0000;
  localparam logic [31:0] V50 = 32'h4248_0000;
  localparam logic [31:0] V60 = 32'h4270_0000;
  localparam logic [31:0] V65 = 32'h4282_0000;
  localparam logic [31:0] V70 = 32'h428C_0000;
  localparam logic [31:0] V75 = 32'h4296_0000;

  typedef struct {
    int   ch;
    logic buy;
    logic sell;
    logic hold;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   n_grants = 0;
  exp_t sb[$];
  int   gq[$];
  logic [31:0] m_lo [NCH];
  logic [31:0] m_hi [NCH];
  int   m_ptr = NCH - 1;
  bit   gap4 = 1'b0;
  bit   have_last = 1'b0;
  int   last_cyc = 0;

  rsi_cmp_sched_if #(.NCH(NCH), .CHW(CHW)) bus ();

  rsi_cmp_sched #(.NCH(NCH), .CHW(CHW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [NCH-1:0] v, input int p);
    for (int i = 1; i <= NCH; i++) begin
      if (v[(p + i) % NCH]) return (p + i) % NCH;
    end
    return -1;
  endfunction

  function automatic exp_t model(input int ch, input logic [31:0] val);
    exp_t     e;
    shortreal v, lo, hi;
    v      = $bitstoshortreal(val);
    lo     = $bitstoshortreal(m_lo[ch]);
    hi     = $bitstoshortreal(m_hi[ch]);
    e.ch   = ch;
    e.sell = (v > hi);
    e.buy  = !e.sell && (lo > v);
    e.hold = !e.sell && !(lo > v);
    return e;
  endfunction

  // Monitor: predict at grant, update model thresholds after, check results.
  always @(negedge clk) begin
    exp_t e;
    int   g;
    if (rst) begin
      sb.delete();
      m_ptr = NCH - 1;
      have_last = 1'b0;
      for (int i = 0; i < NCH; i++) begin
        m_lo[i] = V30;
        m_hi[i] = V70;
      end
    end else begin
      if (bus.req_ready != '0) begin
        g = rr_pick(bus.req_valid, m_ptr);
        check_eq("grant_onehot", 32'(bus.req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
        if (g >= 0) begin
          sb.push_back(model(g, bus.req_value[32*g +: 32]));
          gq.push_back(g);
          m_ptr = g;
          n_grants++;
        end
        if (gap4) begin
          if (have_last) check_eq("grant_gap", 32'(cyc - last_cyc), 32'd4);
          last_cyc  = cyc;
          have_last = 1'b1;
        end else begin
          have_last = 1'b0;
        end
      end
      if (bus.cfg_we && (int'(bus.cfg_ch) < NCH)) begin
        if (bus.cfg_sel) m_hi[bus.cfg_ch] = bus.cfg_data;
        else             m_lo[bus.cfg_ch] = bus.cfg_data;
      end
      if (bus.res_valid) begin
        check_eq("res_has_item", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb[0];
          check_eq("res_ch", 32'(bus.res_ch), 32'(e.ch));
          check_eq("res_buy", 32'(bus.res_buy), 32'(e.buy));
          check_eq("res_sell", 32'(bus.res_sell), 32'(e.sell));
          check_eq("res_hold", 32'(bus.res_hold), 32'(e.hold));
          if (bus.res_ready) void'(sb.pop_front());
        end
      end else begin
        check_eq("res_flags_idle", {29'd0, bus.res_buy, bus.res_sell, bus.res_hold}, 32'd0);
      end
    end
  end

  task automatic send(input int ch, input logic [31:0] v);
    bit got = 1'b0;
    bus.req_value[32*ch +: 32] = v;
    bus.req_valid[ch] = 1'b1;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (bus.req_ready[ch]) got = 1'b1;
    end
    check_eq("send_grant", 32'(got), 32'd1);
    @(posedge clk); #1;
    bus.req_valid[ch] = 1'b0;
  endtask

  task automatic expect_res(input string tag, input int ch, input logic b, input logic s, input logic h);
    bit seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clk);
      if (bus.res_valid) seen = 1'b1;
    end
    check_eq({tag, "_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check_eq({tag, "_ch"}, 32'(bus.res_ch), 32'(ch));
      check_eq({tag, "_bsh"}, {29'd0, bus.res_buy, bus.res_sell, bus.res_hold}, {29'd0, b, s, h});
    end
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int k = 0; k < 60 && !ok; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && !bus.res_valid) ok = 1'b1;
    end
    check_eq("drain", 32'(ok), 32'd1);
  endtask

  initial begin
    bit seen;
    bus.req_valid = '0;
    bus.req_value = '0;
    bus.cfg_we    = 1'b0;
    bus.cfg_ch    = '0;
    bus.cfg_sel   = 1'b0;
    bus.cfg_data  = 32'd0;
    bus.res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check_eq("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check_eq("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check_eq("rst_res_ch", 32'(bus.res_ch), 32'd0);
    check_eq("rst_flags", {29'd0, bus.res_buy, bus.res_sell, bus.res_hold}, 32'd0);

    // 1: ch0 25.0 -> grant at t0, BUY at t0+3
    @(posedge clk); #1;
    bus.res_ready = 1'b1;
    bus.req_value[31:0] = V25;
    bus.req_valid[0] = 1'b1;
    @(negedge clk);
    check_eq("t1_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    bus.req_valid[0] = 1'b0;
    @(negedge clk);
    check_eq("t1_lat1", 32'(bus.res_valid), 32'd0);
    @(negedge clk);
    check_eq("t1_lat2", 32'(bus.res_valid), 32'd0);
    @(negedge clk);
    check_eq("t1_lat3", 32'(bus.res_valid), 32'd1);
    check_eq("t1_buy", {29'd0, bus.res_buy, bus.res_sell, bus.res_hold}, 32'd4);
    drain();

    // 2: sell / hold / value equal to high
    @(posedge clk); #1;
    send(1, V75);
    expect_res("t2_sell", 1, 1'b0, 1'b1, 1'b0);
    send(2, V50);
    expect_res("t2_hold", 2, 1'b0, 1'b0, 1'b1);
    send(3, V70);
    expect_res("t2_eq_high", 3, 1'b0, 1'b0, 1'b1);
    drain();

    // 3: all channels valid -> order 0,1,2,3,0, one grant per 4 cycles
    @(posedge clk); #1;
    gq.delete();
    gap4 = 1'b1;
    bus.req_value = {V70, V50, V75, V25};
    bus.req_valid = 4'hF;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (n_grants >= 9) seen = 1'b1;
    end
    check_eq("t3_five_grants", 32'(seen), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = '0;
    gap4 = 1'b0;
    check_eq("t3_count", 32'(gq.size()), 32'd5);
    if (gq.size() == 5) begin
      check_eq("t3_order", {gq[0][7:0], gq[1][7:0], gq[2][7:0], gq[3][7:0]}, 32'h00010203);
      check_eq("t3_wrap", 32'(gq[4]), 32'd0);
    end
    drain();

    // 4: backpressure in DONE for 5 cycles
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    send(0, V75);
    bus.req_value[63:32] = V50;
    bus.req_valid[1] = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (bus.res_valid) seen = 1'b1;
    end
    check_eq("t4_done", 32'(seen), 32'd1);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      check_eq("t4_valid_held", 32'(bus.res_valid), 32'd1);
      check_eq("t4_no_grant", 32'(bus.req_ready), 32'd0);
      check_eq("t4_sell_held", {29'd0, bus.res_buy, bus.res_sell, bus.res_hold}, 32'd2);
    end
    @(posedge clk); #1;
    bus.res_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("t4_idle_valid", 32'(bus.res_valid), 32'd0);
    check_eq("t4_next_grant", 32'(bus.req_ready), 32'd2);
    @(posedge clk); #1;
    bus.req_valid[1] = 1'b0;
    expect_res("t4_ch1_hold", 1, 1'b0, 1'b0, 1'b1);
    drain();

    // 5: cfg write in the grant cycle applies to the next item only
    @(posedge clk); #1;
    bus.cfg_we   = 1'b1;
    bus.cfg_ch   = 2'd1;
    bus.cfg_sel  = 1'b1;
    bus.cfg_data = V60;
    bus.req_value[63:32] = V65;
    bus.req_valid[1] = 1'b1;
    @(negedge clk);
    check_eq("t5_grant", 32'(bus.req_ready), 32'd2);
    @(posedge clk); #1;
    bus.cfg_we = 1'b0;
    bus.req_valid[1] = 1'b0;
    expect_res("t5_old_thr", 1, 1'b0, 1'b0, 1'b1);
    send(1, V65);
    expect_res("t5_new_thr", 1, 1'b0, 1'b1, 1'b0);
    drain();

    // 6: reset during CMP_LO drops the item and restores thresholds
    @(posedge clk); #1;
    send(2, V25);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("t6_req_ready", 32'(bus.req_ready), 32'd0);
    check_eq("t6_res_valid", 32'(bus.res_valid), 32'd0);
    check_eq("t6_res_ch", 32'(bus.res_ch), 32'd0);
    check_eq("t6_flags", {29'd0, bus.res_buy, bus.res_sell, bus.res_hold}, 32'd0);
    @(posedge clk); #1;
    bus.req_value[63:32]  = V65;
    bus.req_value[127:96] = V20;
    bus.req_valid = 4'b1010;
    @(negedge clk);
    check_eq("t6_first_grant", 32'(bus.req_ready), 32'd2);
    @(posedge clk); #1;
    bus.req_valid[1] = 1'b0;
    expect_res("t6_hi_restored", 1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check_eq("t6_second_grant", 32'(bus.req_ready), 32'd8);
    @(posedge clk); #1;
    bus.req_valid[3] = 1'b0;
    expect_res("t6_buy", 3, 1'b1, 1'b0, 1'b0);
    send(0, V30);
    expect_res("t6_eq_low", 0, 1'b0, 1'b0, 1'b1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
